wdt: RTL and testbench
======================

WDT -- requirements
Module: wdt

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 5'h04: CSR base address. Registers occupy BASE_ADDR+0 .. BASE_ADDR+3.
REQ-002 SHALL have parameter KICK_MAGIC, default 8'h6b: the value that must be written to KICK to service the watchdog.
REQ-003 SHALL have parameter RST_CYCLES, default 16: width of the wdt_rst pulse, in clk cycles; legal range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge clocked.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port ce_1s, input, 1 bit: one-clk-wide clock enable, once per second.
REQ-007 SHALL have port csr_a, input, 5 bits: CSR address.
REQ-008 SHALL have port csr_di, input, 8 bits: CSR write data.
REQ-009 SHALL have port csr_we, input, 1 bit: single-cycle CSR write strobe.
REQ-010 SHALL have port csr_do, output, 8 bits: CSR read data; combinational from csr_a; 8'h00 when csr_a is outside this block's range (the bus is wired-OR).
REQ-011 SHALL have port wdt_rst, output, 1 bit: active-high, registered reset-request pulse.
REQ-012 SHALL have port irq, output, 1 bit: active-high, registered level interrupt.

Function
REQ-013 SHALL implement CTRL at BASE+0, read/write:
- [0] EN; [1] LOCK; [2] RST_EN; [3] IRQ_EN.
- [6:4] read 0.
- [7] TO flag: read 1 = expired; write 1 clears it; write 0 has no effect.
REQ-014 SHALL implement TIMEOUT at BASE+1: 8-bit read/write, in seconds, reset value 8'd10.
REQ-015 SHALL implement KICK at BASE+2: write-only, reads 8'h00.
REQ-016 SHALL implement COUNT at BASE+3: read-only, returns the current 8-bit down-counter.
REQ-017 SHALL use FSM states IDLE, RUN, FIRE and EXPIRED:
- Reset state is IDLE.
- In IDLE, the counter is held at 0.
REQ-018 SHALL go IDLE->RUN on the cycle after a CTRL write sets EN=1, and load the counter with TIMEOUT on that transition.
REQ-019 SHALL, in RUN, decrement the counter by 1 on each ce_1s while the counter is nonzero.
REQ-020 SHALL go RUN->FIRE on a ce_1s with counter==0:
- Covers both counter already 0 and TIMEOUT=0, which expires on the first tick.
- Sets TO.
- Asserts wdt_rst for exactly RST_CYCLES clk cycles if RST_EN=1, else for 0 cycles.
REQ-021 SHALL go FIRE->EXPIRED when the pulse completes, or immediately if RST_EN=0.
REQ-022 SHALL keep the counter at 0 in EXPIRED and never re-fire from there.
REQ-023 SHALL treat a KICK write with csr_di==KICK_MAGIC as follows:
- In RUN or EXPIRED: reload the counter from TIMEOUT and enter RUN.
- In IDLE or FIRE: ignore it.
- A non-magic value is ignored in every state.
REQ-024 SHALL give a kick priority over a ce_1s tick in the same cycle: the counter loads TIMEOUT and no decrement occurs.
REQ-025 SHALL, when a CTRL write clears EN (only possible while LOCK=0), return to IDLE from any state on the next cycle:
- An in-progress wdt_rst pulse is truncated.
- TO is unchanged.
- This write wins over a simultaneous expiry.
REQ-026 SHALL make LOCK sticky once set:
- EN, LOCK and RST_EN cannot be cleared.
- TIMEOUT writes are ignored.
- IRQ_EN, TO-clear and KICK stay functional.
- Only rst_n clears LOCK.
REQ-027 SHALL drive irq = TO & IRQ_EN, registered, i.e. 1 clk after either bit changes.
REQ-028 SHALL make a TIMEOUT write take effect only at the next load; the running count is unaffected.
REQ-029 SHALL give TO set priority over a simultaneous write-1-to-clear.

Reset
REQ-030 SHALL, while rst_n=0, immediately force:
- wdt_rst=0, irq=0.
- CTRL=8'h00, TIMEOUT=8'd10, counter=0.
- FSM=IDLE, pulse counter=0.
- This holds even mid-pulse.
REQ-031 SHALL resume operation on the first clk edge after rst_n deasserts, with no spurious wdt_rst or irq.

Verification
REQ-032 Expiry:
- Stimulus: TIMEOUT=3, CTRL=8'h05, ce_1s every 100 clk.
- Required: COUNT reads 3,2,1,0; wdt_rst high exactly 16 clk after the 4th tick; TO=1; no second pulse after 1000 further ticks.
REQ-033 Kick:
- Stimulus: TIMEOUT=2, run; kick with 8'h6b at COUNT=1; kick with 8'h00 at the next tick.
- Required: the magic kick gives COUNT=2; the non-magic write is ignored; a kick coinciding with ce_1s yields COUNT=2, not 1.
REQ-034 Lock:
- Stimulus: CTRL=8'h07 (locked), then write CTRL=8'h00 and TIMEOUT=5.
- Required: CTRL still reads 8'h07; TIMEOUT still reads 8'd10.
REQ-035 IRQ:
- Stimulus: CTRL=8'h09, TIMEOUT=0, one ce_1s; then write CTRL=8'h89.
- Required: wdt_rst never asserts; irq=1 one clk after TO sets; irq=0 one clk after the clear; csr_do reads 8'h00 for csr_a=BASE+4.
REQ-036 Reset mid-pulse:
- Stimulus: assert rst_n=0 during FIRE cycle 5.
- Required: wdt_rst=0 immediately; all registers read reset values afterwards.

Source files
------------

// File: rtl/wdt.sv
// Watchdog timer with an 8-bit CSR window (CTRL, TIMEOUT, KICK, COUNT).
// Counts down once per ce_1s tick; on expiry sets TO, optionally pulses
// wdt_rst for RST_CYCLES clocks, and can raise a level interrupt.
module wdt #(
  parameter logic [4:0]  BASE_ADDR  = 5'h04,
  parameter logic [7:0]  KICK_MAGIC = 8'h6b,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce_1s,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  output logic       wdt_rst,
  output logic       irq
);

  typedef enum logic [1:0] {IDLE, RUN, FIRE, EXPIRED} state_e;

  localparam logic [7:0] PULSE_LOAD = 8'(RST_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic [7:0] timeout_q, timeout_d;
  logic       en_q, en_d;
  logic       lock_q, lock_d;
  logic       rst_en_q, rst_en_d;
  logic       irq_en_q, irq_en_d;
  logic       to_q, to_d;
  logic       wdt_rst_q, wdt_rst_d;
  logic       irq_q, irq_d;

  logic [5:0] ofs;
  logic       in_range;
  logic       ctrl_wr, tout_wr, kick_ok;
  logic       fire;

  // Address decode: offset is computed one bit wider so addresses below
  // the base wrap to large values and fall out of range.
  always_comb begin
    ofs      = {1'b0, csr_a} - {1'b0, BASE_ADDR};
    in_range = (ofs < 6'd4);
    ctrl_wr  = csr_we && in_range && (ofs[1:0] == 2'd0);
    tout_wr  = csr_we && in_range && (ofs[1:0] == 2'd1);
    kick_ok  = csr_we && in_range && (ofs[1:0] == 2'd2) && (csr_di == KICK_MAGIC);
  end

  // Read mux: zero outside our window so the bus can be wired-OR.
  always_comb begin
    csr_do = 8'h00;
    if (in_range) begin
      case (ofs[1:0])
        2'd0:    csr_do = {to_q, 3'b000, irq_en_q, rst_en_q, lock_q, en_q};
        2'd1:    csr_do = timeout_q;
        2'd3:    csr_do = cnt_q;
        default: csr_do = 8'h00;
      endcase
    end
  end

  // Control register next-state; LOCK makes EN/LOCK/RST_EN set-only and
  // freezes TIMEOUT.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    en_d      = en_q;
    lock_d    = lock_q;
    rst_en_d  = rst_en_q;
    irq_en_d  = irq_en_q;
    timeout_d = timeout_q;
    if (ctrl_wr) begin
      en_d     = csr_di[0] | (lock_q & en_q);
      lock_d   = csr_di[1] | lock_q;
      rst_en_d = csr_di[2] | (lock_q & rst_en_q);
      irq_en_d = csr_di[3];
    end
    if (tout_wr && !lock_q) timeout_d = csr_di;
  end

  // FSM, down-counter and reset-pulse timer next-state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q;
    wdt_rst_d = 1'b0;
    fire      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (ctrl_wr && en_d) begin
          state_d = RUN;
          cnt_d   = timeout_q;
        end
      end
      RUN: begin
        // A kick beats a same-cycle tick.
        if (kick_ok) begin
          cnt_d = timeout_q;
        end else if (ce_1s) begin
          if (cnt_q == 8'd0) begin
            state_d   = FIRE;
            fire      = 1'b1;
            wdt_rst_d = rst_en_q;
            pcnt_d    = rst_en_q ? PULSE_LOAD : 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      FIRE: begin
        cnt_d = 8'd0;
        if (wdt_rst_q && (pcnt_q != 8'd0)) begin
          wdt_rst_d = 1'b1;
          pcnt_d    = pcnt_q - 8'd1;
        end else begin
          state_d = EXPIRED;
          pcnt_d  = 8'd0;
        end
      end
      EXPIRED: begin
        cnt_d = 8'd0;
        if (kick_ok) begin
          state_d = RUN;
          cnt_d   = timeout_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    // Disabling wins over everything, including a same-cycle expiry.
    if (ctrl_wr && !en_d) begin
      state_d   = IDLE;
      cnt_d     = 8'd0;
      pcnt_d    = 8'd0;
      wdt_rst_d = 1'b0;
      fire      = 1'b0;
    end
    // TO: write-1-to-clear, but a same-cycle expiry sets it.
    to_d = to_q;
    if (ctrl_wr && csr_di[7]) to_d = 1'b0;
    if (fire)                 to_d = 1'b1;
    irq_d = to_q & irq_en_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      pcnt_q    <= 8'd0;
      timeout_q <= 8'd10;
      en_q      <= 1'b0;
      lock_q    <= 1'b0;
      rst_en_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      to_q      <= 1'b0;
      wdt_rst_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      timeout_q <= timeout_d;
      en_q      <= en_d;
      lock_q    <= lock_d;
      rst_en_q  <= rst_en_d;
      irq_en_q  <= irq_en_d;
      to_q      <= to_d;
      wdt_rst_q <= wdt_rst_d;
      irq_q     <= irq_d;
    end
  end

  assign wdt_rst = wdt_rst_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_wdt.sv
// Self-checking bench for wdt: expected values are queued when stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_wdt;

  localparam logic [4:0] A_CTRL = 5'h04;
  localparam logic [4:0] A_TOUT = 5'h05;
  localparam logic [4:0] A_KICK = 5'h06;
  localparam logic [4:0] A_CNT  = 5'h07;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce_1s = 1'b0;
  logic [4:0] csr_a = 5'h00;
  logic [7:0] csr_di = 8'h00;
  logic       csr_we = 1'b0;
  logic [7:0] csr_do;
  logic       wdt_rst;
  logic       irq;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  wdt #(.BASE_ADDR(5'h04), .KICK_MAGIC(8'h6b), .RST_CYCLES(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce_1s   (ce_1s),
    .csr_a   (csr_a),
    .csr_di  (csr_di),
    .csr_we  (csr_we),
    .csr_do  (csr_do),
    .wdt_rst (wdt_rst),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(string tag, logic [7:0] act, logic [7:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %02h expected %02h", tag, act, exp);
  endtask

  task automatic sb_push(string tag, logic [7:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop_check(logic [7:0] act);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 8'(sb_q.size()), 8'd1);
    end else begin
      it = sb_q.pop_front();
      check(it.tag, act, it.exp);
    end
  endtask

  task automatic expect_rd(string tag, logic [4:0] addr, logic [7:0] exp);
    csr_a = addr;
    sb_push(tag, exp);
    #1;
    sb_pop_check(csr_do);
  endtask

  task automatic expect_rst(string tag, logic exp);
    sb_push(tag, {7'd0, exp});
    sb_pop_check({7'd0, wdt_rst});
  endtask

  task automatic expect_irq(string tag, logic exp);
    sb_push(tag, {7'd0, exp});
    sb_pop_check({7'd0, irq});
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(logic [4:0] addr, logic [7:0] data);
    csr_a  = addr;
    csr_di = data;
    csr_we = 1'b1;
    @(posedge clk);
    #1;
    csr_we = 1'b0;
  endtask

  task automatic tick_s();
    ce_1s = 1'b1;
    @(posedge clk);
    #1;
    ce_1s = 1'b0;
  endtask

  task automatic wr_with_tick(logic [4:0] addr, logic [7:0] data);
    csr_a  = addr;
    csr_di = data;
    csr_we = 1'b1;
    ce_1s  = 1'b1;
    @(posedge clk);
    #1;
    csr_we = 1'b0;
    ce_1s  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int hi;

    // Reset values
    do_reset();
    expect_rd("rst_ctrl", A_CTRL, 8'h00);
    expect_rd("rst_tout", A_TOUT, 8'd10);
    expect_rd("rst_cnt",  A_CNT,  8'h00);
    expect_rd("rst_kick", A_KICK, 8'h00);
    expect_rst("rst_wdt_rst", 1'b0);
    expect_irq("rst_irq", 1'b0);

    // Expiry with 100-clk tick spacing
    csr_wr(A_TOUT, 8'd3);
    csr_wr(A_CTRL, 8'h05);
    expect_rd("exp_cnt3", A_CNT, 8'd3);
    for (int i = 1; i <= 3; i++) begin
      cycles(99);
      tick_s();
      expect_rd($sformatf("exp_cnt_t%0d", i), A_CNT, 8'(3 - i));
      expect_rst("exp_no_rst_early", 1'b0);
    end
    cycles(99);
    tick_s();
    n = 0;
    while (wdt_rst === 1'b1 && n < 64) begin
      n++;
      @(posedge clk);
      #1;
    end
    sb_push("exp_pulse_width", 8'd16);
    sb_pop_check(8'(n));
    expect_rd("exp_ctrl_to", A_CTRL, 8'h85);
    expect_rd("exp_cnt_zero", A_CNT, 8'h00);
    hi = 0;
    for (int k = 0; k < 1000; k++) begin
      tick_s();
      if (wdt_rst === 1'b1) hi++;
      @(posedge clk);
      #1;
      if (wdt_rst === 1'b1) hi++;
    end
    sb_push("exp_no_refire", 8'd0);
    sb_pop_check(8'(hi));
    expect_rd("exp_cnt_stays0", A_CNT, 8'h00);

    // Kick behaviour
    do_reset();
    csr_wr(A_KICK, 8'h6b);
    expect_rd("kick_idle_ignored", A_CNT, 8'h00);
    csr_wr(A_TOUT, 8'd2);
    csr_wr(A_CTRL, 8'h01);
    expect_rd("kick_cnt_load", A_CNT, 8'd2);
    tick_s();
    expect_rd("kick_cnt_dec", A_CNT, 8'd1);
    csr_wr(A_KICK, 8'h6b);
    expect_rd("kick_magic", A_CNT, 8'd2);
    tick_s();
    expect_rd("kick_cnt_dec2", A_CNT, 8'd1);
    wr_with_tick(A_KICK, 8'h00);
    expect_rd("kick_nonmagic", A_CNT, 8'd0);
    wr_with_tick(A_KICK, 8'h6b);
    expect_rd("kick_beats_tick", A_CNT, 8'd2);
    expect_rd("kick_no_to", A_CTRL, 8'h01);
    csr_wr(A_TOUT, 8'd7);
    expect_rd("tout_no_effect", A_CNT, 8'd2);
    expect_rd("tout_readback", A_TOUT, 8'd7);
    csr_wr(A_KICK, 8'h6b);
    expect_rd("tout_next_load", A_CNT, 8'd7);

    // Lock
    do_reset();
    csr_wr(A_CTRL, 8'h07);
    csr_wr(A_CTRL, 8'h00);
    csr_wr(A_TOUT, 8'd5);
    expect_rd("lock_ctrl", A_CTRL, 8'h07);
    expect_rd("lock_tout", A_TOUT, 8'd10);
    csr_wr(A_CTRL, 8'h08);
    expect_rd("lock_irq_en_free", A_CTRL, 8'h0f);

    // IRQ path, no reset pulse
    do_reset();
    csr_wr(A_TOUT, 8'd0);
    csr_wr(A_CTRL, 8'h09);
    tick_s();
    expect_rd("irq_to_set", A_CTRL, 8'h89);
    expect_irq("irq_lag", 1'b0);
    expect_rst("irq_no_rst", 1'b0);
    cycles(1);
    expect_irq("irq_high", 1'b1);
    expect_rst("irq_no_rst2", 1'b0);
    csr_wr(A_CTRL, 8'h89);
    expect_rd("irq_to_clr", A_CTRL, 8'h09);
    expect_irq("irq_clr_lag", 1'b1);
    cycles(1);
    expect_irq("irq_low", 1'b0);
    expect_rd("addr_above", 5'h08, 8'h00);
    expect_rd("addr_below", 5'h03, 8'h00);

    // Disable truncates an in-progress pulse, TO kept
    do_reset();
    csr_wr(A_TOUT, 8'd0);
    csr_wr(A_CTRL, 8'h05);
    tick_s();
    expect_rst("dis_pulse_on", 1'b1);
    cycles(2);
    csr_wr(A_CTRL, 8'h04);
    expect_rst("dis_truncate", 1'b0);
    expect_rd("dis_ctrl", A_CTRL, 8'h84);
    cycles(20);
    expect_rst("dis_stays_low", 1'b0);

    // Reset mid-pulse
    do_reset();
    csr_wr(A_TOUT, 8'd0);
    csr_wr(A_CTRL, 8'h05);
    tick_s();
    cycles(4);
    expect_rst("mid_pulse_on", 1'b1);
    rst_n = 1'b0;
    #1;
    expect_rst("mid_async_clr", 1'b0);
    expect_irq("mid_irq_clr", 1'b0);
    expect_rd("mid_ctrl_in_rst", A_CTRL, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    expect_rd("post_ctrl", A_CTRL, 8'h00);
    expect_rd("post_tout", A_TOUT, 8'd10);
    expect_rd("post_cnt",  A_CNT,  8'h00);
    cycles(20);
    expect_rst("post_no_rst", 1'b0);
    expect_irq("post_no_irq", 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
